// File: rtl/floatdiv_iter.sv
// floatdiv_iter: iterative restoring IEEE-754 single-precision divider, one quotient bit per clock,
// truncating, denormals flushed to zero, valid/ready handshake on both sides.
module floatdiv_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127,
    parameter int QBITS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic        dz,
    output logic        inv
);
    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [MAN_W-1:0] MZERO = '0;

    state_t             r_state, w_next;
    logic               r_sign;
    logic [EXP_W-1:0]   r_ea, r_eb;
    logic [MAN_W:0]     r_mb;
    logic [MAN_W+2:0]   r_rem;
    logic [QBITS-1:0]   r_q;
    logic [4:0]         r_cnt;
    logic [31:0]        r_s;
    logic               r_dz, r_inv;

    logic [EXP_W-1:0]   w_ea, w_eb;
    logic               w_sign, w_nan, w_dz, w_special, w_ge;
    logic [31:0]        w_spec_s, w_norm_s;
    logic [MAN_W+2:0]   w_diff;
    logic signed [9:0]  w_e;
    logic [MAN_W-1:0]   w_man;

    assign w_ea      = a[30:23];
    assign w_eb      = b[30:23];
    assign w_sign    = a[31] ^ b[31];
    assign w_nan     = (w_ea == '0 && w_eb == '0) || (w_ea == EMAX && w_eb == EMAX);
    assign w_dz      = !w_nan && w_eb == '0;
    assign w_special = w_eb == '0 || w_ea == '0 || w_ea == EMAX || w_eb == EMAX;
    assign w_spec_s  = w_nan ? 32'h7FC0_0000 :
                       (w_eb == '0 || w_ea == EMAX) ? {w_sign, EMAX, MZERO} : {w_sign, 31'd0};

    assign w_ge   = r_rem >= {2'b0, r_mb};
    assign w_diff = r_rem - {2'b0, r_mb};

    // A quotient below 1.0 leaves its leading one in bit 23 and costs one exponent step
    assign w_e      = 10'(r_ea) - 10'(r_eb) + 10'(BIAS) - 10'(!r_q[QBITS-1]);
    assign w_man    = r_q[QBITS-1] ? r_q[MAN_W:1] : r_q[MAN_W-1:0];
    assign w_norm_s = (w_e >= 10'sd255) ? {r_sign, EMAX, MZERO} :
                      (w_e <= 10'sd0) ? {r_sign, 31'd0} : {r_sign, w_e[EXP_W-1:0], w_man};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = w_special ? DONE : DIV;
            DIV:     if (r_cnt == 5'(QBITS - 1)) w_next = NORM;
            NORM:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
    end

    assign s   = r_s;
    assign dz  = r_dz;
    assign inv = r_inv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_dz   <= 1'b0;
            r_inv  <= 1'b0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_mb   <= '0;
            r_sign <= 1'b0;
            r_ea   <= '0;
            r_eb   <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign <= w_sign;
                    r_ea   <= w_ea;
                    r_eb   <= w_eb;
                    r_mb   <= {1'b1, b[MAN_W-1:0]};
                    r_rem  <= {2'b0, 1'b1, a[MAN_W-1:0]};
                    r_q    <= '0;
                    r_cnt  <= '0;
                    r_dz   <= w_dz;
                    r_inv  <= w_nan;
                    if (w_special) r_s <= w_spec_s;
                end
                DIV: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= (w_ge ? w_diff : r_rem) << 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                NORM: r_s <= w_norm_s;
                DONE: if (out_ready) begin
                    r_dz  <= 1'b0;
                    r_inv <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_floatdiv_iter.sv
// tb_floatdiv_iter: directed and random checks of floatdiv_iter against an integer-division reference model.
module tb_floatdiv_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, dz, inv;
    logic [31:0] s;
    int          checks = 0;
    int          failures = 0;

    floatdiv_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .dz(dz), .inv(inv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Quotient mantissa is floor(ma * 2^24 / mb): exactly what 25 truncated quotient bits hold
    function automatic void model(input logic [31:0] x, input logic [31:0] y, output logic [31:0] es,
                                  output logic edz, output logic einv, output int elat);
        int ex, ey, e;
        logic sg;
        longint unsigned q;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sg = x[31] ^ y[31];
        edz = 1'b0;
        einv = 1'b0;
        elat = 1;
        e = 0;
        q = 0;
        if ((ex == 0 && ey == 0) || (ex == 255 && ey == 255)) begin
            es = 32'h7FC0_0000;
            einv = 1'b1;
        end else if (ey == 0) begin
            es = {sg, 8'hFF, 23'd0};
            edz = 1'b1;
        end else if (ex == 255) es = {sg, 8'hFF, 23'd0};
        else if (ex == 0 || ey == 255) es = {sg, 31'd0};
        else begin
            elat = 27;
            q = ({40'd0, 1'b1, x[22:0]} << 24) / {40'd0, 1'b1, y[22:0]};
            if (q >= (64'd1 << 24)) begin
                q = q >> 1;
                e = ex - ey + 127;
            end else e = ex - ey + 126;
            if (e >= 255) es = {sg, 8'hFF, 23'd0};
            else if (e <= 0) es = {sg, 31'd0};
            else es = {sg, 8'(e), q[22:0]};
        end
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] y, output int lat);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = x;
        b = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_exp(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] es, input logic edz, input logic einv, input int elat);
        int lat;
        issue(x, y, lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_s"}, s, es);
        chk({tag, "_dz"}, {31'd0, dz}, {31'd0, edz});
        chk({tag, "_inv"}, {31'd0, inv}, {31'd0, einv});
        release_out();
        chk({tag, "_s_held"}, s, es);
        chk({tag, "_flags_clr"}, {30'd0, dz, inv}, 32'd0);
    endtask

    function automatic logic [7:0] rand_exp();
        int r;
        r = $urandom_range(0, 9);
        return r == 0 ? 8'd0 : r == 1 ? 8'd255 : 8'($urandom_range(1, 254));
    endfunction

    initial begin
        logic [31:0] x, y, es;
        logic edz, einv;
        int elat, lat;
        repeat (3) step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_flags", {30'd0, dz, inv}, 32'd0);
        rst_n = 1'b1;
        step();
        run_exp("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 27);
        run_exp("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 27);
        run_exp("neg_eight_half", 32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, 1'b0, 1'b0, 27);
        run_exp("div_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0, 1);
        run_exp("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1, 1);
        run_exp("inf_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 1);
        run_exp("neg_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1'b0, 1);
        run_exp("inf_by_one", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 1);
        run_exp("one_by_neg_inf", 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
        run_exp("denorm_flush", 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
        run_exp("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 1'b0, 27);
        run_exp("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0, 27);

        issue(32'h40C0_0000, 32'h4000_0000, lat);
        chk("bp_lat", lat, 27);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            step();
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_s", s, 32'h4040_0000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        repeat (3) step();
        chk("bp_no_ghost_op", {31'd0, out_valid}, 32'd0);

        chk("mid_rst_in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = 32'h40C0_0000;
        b = 32'h4000_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_s", s, 32'd0);
        repeat (30) step();
        chk("mid_rst_abandoned", {31'd0, out_valid}, 32'd0);
        run_exp("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 27);

        for (int i = 0; i < 40; i++) begin
            x = {1'($urandom), rand_exp(), 23'($urandom)};
            y = {1'($urandom), rand_exp(), 23'($urandom)};
            model(x, y, es, edz, einv, elat);
            run_exp("random", x, y, es, edz, einv, elat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
